// File: rtl/wam_n_hole.sv
// rtl/wam_n_hole.sv - whack-a-mole game core: debounced inputs, LFSR mole placement, score/lives FSM (optional speed-up under WAM_SPEEDUP_EN)
module wam_n_hole #(
    parameter int N_HOLES     = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int MOLE_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    parameter int START_LIVES = 3,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HOLES-1:0] button,
    input  logic               start,
    output logic [N_HOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic [1:0]         state
);
    localparam int NI   = N_HOLES + 1;
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int HW   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SHOW = 2'b01,
        S_GAP  = 2'b10,
        S_END  = 2'b11
    } st_t;

    // Input conditioning: bit N_HOLES is start, lower bits are the hole buttons
    logic [NI-1:0] raw, sync1, sync2, samp, deb, arm, press;
    logic [DW-1:0] cnt [NI];

    assign raw = {start, button};

    // Two-flop synchroniser for every raw input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a level after DEB_CYCLES identical samples; a press pulse
    // needs a previously accepted low level, so buttons held through reset stay silent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp  <= '0;
            deb   <= '0;
            arm   <= '0;
            press <= '0;
            for (int i = 0; i < NI; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != samp[i]) begin
                    samp[i] <= sync2[i];
                    cnt[i]  <= DW'(1);
                end else if (cnt[i] != DW'(DEB_CYCLES - 1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    deb[i] <= samp[i];
                    if (!samp[i])
                        arm[i] <= 1'b1;
                    else if (!deb[i] && arm[i])
                        press[i] <= 1'b1;
                end
            end
        end
    end

    logic               start_p;
    logic [N_HOLES-1:0] btn_p;
    assign start_p = press[N_HOLES];
    assign btn_p   = press[N_HOLES-1:0];

    // Free-running 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1)
    logic [7:0] lfsr, lfsr_nx;
    assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= lfsr_nx;
    end

    // Game registers
    st_t                st, st_n;
    logic [N_HOLES-1:0] mole_r, mole_n;
    logic [SCORE_W-1:0] score_r, score_n;
    logic [3:0]         lives_r, lives_n;
    logic [TW-1:0]      timer, timer_n;
    logic [HW-1:0]      prev_hole, prev_n;
    logic               prev_valid, pv_n;
    logic [TW-1:0]      window;

`ifdef WAM_SPEEDUP_EN
    localparam int DEC   = MOLE_CYCLES / 8;
    localparam int FLOOR = MOLE_CYCLES / 4;
    logic [TW-1:0] window_n;
    logic [1:0]    hitq, hitq_n;
`else
    assign window = TW'(MOLE_CYCLES);
`endif

    // Hole draw: LFSR value, then next value, then neighbour if both repeat the last hole
    logic [7:0]         ma, mb;
    logic [HW-1:0]      hole_a, hole_b, new_hole;
    logic [N_HOLES-1:0] onehot;

    always_comb begin
        ma     = lfsr % 8'(N_HOLES);
        mb     = lfsr_nx % 8'(N_HOLES);
        hole_a = ma[HW-1:0];
        hole_b = mb[HW-1:0];
        if (!prev_valid || hole_a != prev_hole)
            new_hole = hole_a;
        else if (hole_b != prev_hole)
            new_hole = hole_b;
        else if (prev_hole == HW'(N_HOLES - 1))
            new_hole = '0;
        else
            new_hole = prev_hole + 1'b1;
        onehot           = '0;
        onehot[new_hole] = 1'b1;
    end

    logic hit, miss_press, expire;
    assign hit        = |(btn_p & mole_r);
    assign miss_press = |(btn_p & ~mole_r);
    assign expire     = (timer == window - 1'b1);

    // State and game registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            mole_r     <= '0;
            score_r    <= '0;
            lives_r    <= '0;
            timer      <= '0;
            prev_hole  <= '0;
            prev_valid <= 1'b0;
`ifdef WAM_SPEEDUP_EN
            window     <= TW'(MOLE_CYCLES);
            hitq       <= '0;
`endif
        end else begin
            st         <= st_n;
            mole_r     <= mole_n;
            score_r    <= score_n;
            lives_r    <= lives_n;
            timer      <= timer_n;
            prev_hole  <= prev_n;
            prev_valid <= pv_n;
`ifdef WAM_SPEEDUP_EN
            window     <= window_n;
            hitq       <= hitq_n;
`endif
        end
    end

    // Next-state: hits take priority over every kind of miss
    always_comb begin
        st_n    = st;
        mole_n  = mole_r;
        score_n = score_r;
        lives_n = lives_r;
        timer_n = timer + 1'b1;
        prev_n  = prev_hole;
        pv_n    = prev_valid;
`ifdef WAM_SPEEDUP_EN
        window_n = window;
        hitq_n   = hitq;
`endif
        case (st)
            S_IDLE: begin
                mole_n  = '0;
                timer_n = '0;
                if (start_p) begin
                    score_n = '0;
                    lives_n = 4'(START_LIVES);
                    pv_n    = 1'b0;
                    st_n    = S_GAP;
`ifdef WAM_SPEEDUP_EN
                    window_n = TW'(MOLE_CYCLES);
                    hitq_n   = '0;
`endif
                end
            end
            S_GAP: begin
                mole_n = '0;
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    st_n    = S_SHOW;
                    timer_n = '0;
                    mole_n  = onehot;
                    prev_n  = new_hole;
                    pv_n    = 1'b1;
                end
            end
            S_SHOW: begin
                if (hit) begin
                    score_n = (score_r == '1) ? score_r : score_r + 1'b1;
                    mole_n  = '0;
                    timer_n = '0;
                    st_n    = S_GAP;
`ifdef WAM_SPEEDUP_EN
                    hitq_n = hitq + 1'b1;
                    if (hitq == 2'd3)
                        window_n = (window > TW'(FLOOR + DEC)) ? window - TW'(DEC) : TW'(FLOOR);
`endif
                end else if (miss_press || expire) begin
                    lives_n = (lives_r != 4'd0) ? lives_r - 4'd1 : 4'd0;
                    if (lives_r <= 4'd1) begin
                        st_n    = S_END;
                        mole_n  = '0;
                        timer_n = '0;
                    end else if (expire) begin
                        st_n    = S_GAP;
                        mole_n  = '0;
                        timer_n = '0;
                    end
                end
            end
            default: begin
                mole_n  = '0;
                timer_n = '0;
                if (start_p) st_n = S_IDLE;
            end
        endcase
    end

    assign mole  = mole_r;
    assign score = score_r;
    assign lives = lives_r;
    assign state = st;
endmodule

// File: tb/tb_wam_n_hole.sv
// tb/tb_wam_n_hole.sv - directed scoreboard bench for wam_n_hole
module tb_wam_n_hole;
    localparam int N = 4;
`ifdef WAM_SPEEDUP_EN
    localparam int WIN16 = 20;
`else
    localparam int WIN16 = 40;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] button = '0;
    logic         start = 1'b0;
    logic [N-1:0] mole;
    logic [3:0]   score;
    logic [3:0]   lives;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;
    int pc0 = 0;
    int pcs = 0;
    string tq[$];
    int    eq[$];

    wam_n_hole #(
        .N_HOLES(N), .DEB_CYCLES(4), .MOLE_CYCLES(40),
        .GAP_CYCLES(8), .START_LIVES(3), .SCORE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .start(start),
        .mole(mole), .score(score), .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.press[0]) pc0++;
        if (dut.press[N]) pcs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string t, input int e);
        tq.push_back(t);
        eq.push_back(e);
    endtask

    task automatic sb_check(input int obs);
        string t;
        int e;
        t = tq.pop_front();
        e = eq.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic wait_state(input int target, input int bound, input string t);
        int n;
        n = 0;
        while (int'(state) != target && n < bound) begin
            tick();
            n++;
        end
        if (int'(state) != target) begin
            sb_push(t, target);
            sb_check(int'(state));
        end
    endtask

    task automatic hit_lit(input int exp_score);
        button = mole;
        repeat (7) tick();
        sb_push("hit_score", exp_score); sb_check(int'(score));
        sb_push("hit_state", 2);         sb_check(int'(state));
        sb_push("hit_mole", 0);          sb_check(int'(mole));
    endtask

    task automatic measure_window(input int exp_len);
        int n;
        wait_state(1, 30, "show_timeout");
        n = 0;
        while (int'(state) == 1 && n < 100) begin
            tick();
            n++;
        end
        sb_push("window_len", exp_len);
        sb_check(n);
    endtask

    initial begin
        int base, k, h, m0;
        #1;
        sb_push("rst_state", 0); sb_check(int'(state));
        sb_push("rst_mole", 0);  sb_check(int'(mole));
        sb_push("rst_score", 0); sb_check(int'(score));
        sb_push("rst_lives", 0); sb_check(int'(lives));
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();

        // Bouncy start: five 2-cycle levels ending high, one pulse 6 cycles later
        base = pcs;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            if (i < 4) repeat (2) tick();
        end
        k = 0;
        while (!dut.press[N] && k < 20) begin
            tick();
            k++;
        end
        sb_push("deb_latency", 6); sb_check(k);
        tick();
        sb_push("start_gap", 2);   sb_check(int'(state));
        sb_push("start_lives", 3); sb_check(int'(lives));
        sb_push("start_score", 0); sb_check(int'(score));
        repeat (20) tick();
        sb_push("deb_one_pulse", base + 1); sb_check(pcs);
        start = 1'b0;

        // Hit on the lit hole
        wait_state(1, 30, "show_timeout");
        hit_lit(1);
        button = '0;
        repeat (8) tick();

        // Lit and unlit together: hit wins
        wait_state(1, 30, "show_timeout");
        button = mole | ((mole == 4'b0001) ? 4'b0010 : 4'b0001);
        repeat (7) tick();
        sb_push("both_score", 2); sb_check(int'(score));
        sb_push("both_lives", 3); sb_check(int'(lives));
        button = '0;
        repeat (8) tick();

        // Unlit press: life lost, mole and window kept
        wait_state(1, 30, "show_timeout");
        m0 = int'(mole);
        h = (m0 == 1) ? 2 : 1;
        button = 4'(h);
        repeat (7) tick();
        sb_push("miss_lives", 2); sb_check(int'(lives));
        sb_push("miss_state", 1); sb_check(int'(state));
        sb_push("miss_mole", m0); sb_check(int'(mole));
        button = '0;
        wait_state(2, 60, "expire_timeout");
        sb_push("expire_lives", 1); sb_check(int'(lives));
        measure_window(40);
        sb_push("end_lives", 0); sb_check(int'(lives));
        sb_push("end_state", 3); sb_check(int'(state));
        sb_push("end_mole", 0);  sb_check(int'(mole));

        // END freezes; start returns to IDLE
        button = 4'b0001;
        repeat (7) tick();
        sb_push("end_frozen_score", 2); sb_check(int'(score));
        button = '0;
        repeat (8) tick();
        start = 1'b1;
        repeat (7) tick();
        sb_push("end_to_idle", 0); sb_check(int'(state));
        start = 1'b0;
        repeat (8) tick();

        // New game: 16 hits saturate the score
        start = 1'b1;
        repeat (7) tick();
        sb_push("new_score", 0); sb_check(int'(score));
        sb_push("new_lives", 3); sb_check(int'(lives));
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            wait_state(1, 30, "show_timeout");
            hit_lit((i > 15) ? 15 : i);
            if (i < 16) begin
                button = '0;
                repeat (8) tick();
            end
        end
        sb_push("sat_lives", 3); sb_check(int'(lives));
        measure_window(WIN16);
        button = '0;
        sb_push("win_expire_lives", 2); sb_check(int'(lives));

        // Reset mid-SHOW with a button held
        repeat (8) tick();
        wait_state(1, 30, "show_timeout");
        button = 4'b0001;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        sb_push("midrst_state", 0); sb_check(int'(state));
        sb_push("midrst_mole", 0);  sb_check(int'(mole));
        sb_push("midrst_score", 0); sb_check(int'(score));
        sb_push("midrst_lives", 0); sb_check(int'(lives));
        base = pc0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        sb_push("held_no_pulse", base); sb_check(pc0);
        button = '0;
        repeat (10) tick();
        button = 4'b0001;
        repeat (8) tick();
        sb_push("repress_pulse", base + 1); sb_check(pc0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wam_n_hole.md
WAM_N_HOLE -- requirements
Module: wam_n_hole

Interface
REQ-001 Parameter N_HOLES, default 4: number of holes/buttons/moles; legal range 2..16.
REQ-002 Parameter DEB_CYCLES, default 1_000_000: clock cycles a synchronised button level must stay stable before it is accepted.
REQ-003 Parameter MOLE_CYCLES, default 100_000_000: mole visible window in cycles.
REQ-004 Parameter GAP_CYCLES, default 25_000_000: blank time between moles in cycles.
REQ-005 Parameter START_LIVES, default 3: lives loaded at game start; range 1..15.
REQ-006 Parameter SCORE_W, default 4: score counter width.
REQ-007 clk  input  1  system clock, all logic rising-edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 button  input  N_HOLES  raw, bouncy, asynchronous push-buttons, one per hole.
REQ-010 start  input  1  raw start button, debounced identically to button.
REQ-011 mole  output  N_HOLES  one-hot or zero; bit i high = mole shown in hole i.
REQ-012 score  output  SCORE_W  hits this game.
REQ-013 lives  output  4  remaining lives.
REQ-014 state  output  2  00 IDLE, 01 SHOW, 10 GAP, 11 END.

Function
REQ-015 Each button and start SHALL pass a 2-flop synchroniser then a debounce counter; debounced rising edge yields a one-cycle press pulse.
REQ-016 Debounce: level accepted only after DEB_CYCLES consecutive identical synchronised samples; any change restarts the count.
REQ-017 An 8-bit maximal-length LFSR (seed 8'hA5, never zero) SHALL advance every cycle; new mole hole = LFSR value mod N_HOLES, re-drawn (next value) if equal to previous hole.
REQ-018 IDLE: mole=0; start press loads score=0, lives=START_LIVES, goes GAP.
REQ-019 GAP: mole=0; after GAP_CYCLES enters SHOW with new hole; presses ignored.
REQ-020 SHOW: press on lit hole = hit: score+1 (saturate at all-ones), mole cleared next cycle, go GAP.
REQ-021 SHOW: press on unlit hole only = miss: lives-1, mole stays, window timer continues.
REQ-022 SHOW: window expiry (MOLE_CYCLES) without hit = miss: lives-1, go GAP.
REQ-023 Simultaneous pulses on lit and unlit holes in one cycle: hit wins, no life lost.
REQ-024 Hit and window expiry in the same cycle: hit wins.
REQ-025 Any miss that takes lives to 0 SHALL enter END next cycle; lives never underflow.
REQ-026 END: mole=0, score and lives frozen; start press returns to IDLE.
REQ-027 start press in SHOW or GAP SHALL be ignored.
REQ-028 All outputs registered; press pulse to score/lives update latency exactly 1 cycle after pulse.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, mole=0, score=0, lives=0, all timers/debouncers to 0, debounced levels to 0, LFSR to seed.
REQ-030 Reset mid-game SHALL discard game; no press pulse generated for buttons held through reset release until released and re-pressed.

Configuration
REQ-031 Macro WAM_SPEEDUP_EN defined: every 4th hit reduces the mole window by MOLE_CYCLES/8, floor MOLE_CYCLES/4; window restored to MOLE_CYCLES at game start.
REQ-032 Macro WAM_SPEEDUP_EN undefined: window fixed at MOLE_CYCLES; no speed-up logic synthesised.

Verification (N_HOLES=4, DEB_CYCLES=4, MOLE_CYCLES=40, GAP_CYCLES=8, START_LIVES=3, SCORE_W=4)
REQ-033 Bouncy button (toggle every 2 cycles for 10 cycles, then stable high) -> exactly one press pulse, 4+2 cycles after last edge.
REQ-034 Start, wait for SHOW, press lit hole -> score 0->1, mole=0 and state=GAP one cycle after pulse.
REQ-035 Let three windows expire -> lives 3->2->1->0, state=END, mole=0; start -> IDLE.
REQ-036 In SHOW press lit and unlit holes in same cycle -> score+1, lives unchanged; 16 hits -> score saturates at 15.
REQ-037 Assert reset mid-SHOW with button held -> all outputs reset immediately; no press after release until button released and re-pressed.
REQ-038 With WAM_SPEEDUP_EN, 4 hits -> next window 35 cycles; 24 hits -> window floored at 10.
